regfile_scoreboard: RTL
=======================

# regfile_scoreboard

Parametrised integer register file for the NPC core, with two combinational read ports, one write-back port and a per-register pending-write scoreboard. It replaces the fixed single-cycle register file once decode and write-back sit in different pipeline stages. Decode reserves a destination at issue; write-back retires it. Read ports report data plus a busy flag so decode can stall on RAW hazards.

## Interface
- XLEN, 32: data width of each register.
- NREG, 16: number of architectural registers; 16 for RV32E, 32 for RV32I.
- AW, $clog2(NREG): register address width.
- PCNT_W, 2: width of each pending counter; at most 2^PCNT_W-1 outstanding writes per register.
- RST_VAL, 0: reset value of registers x1..x(NREG-1).

- clk  in  1  clock; all state changes on posedge.
- rst  in  1  reset, synchronous, active-high.
- rs1, rs2  in  AW  read addresses.
- src1, src2  out  XLEN  read data.
- busy1, busy2  out  1  the addressed register still has an unretired write.
- issue_valid  in  1  decode reserves issue_rd.
- issue_rd  in  AW  destination being reserved.
- issue_ready  out  1  reservation accepted this cycle.
- wb_valid  in  1  write-back strobe.
- wb_rd  in  AW  write-back destination.
- wb_data  in  XLEN  write-back data.
- err  out  1  sticky scoreboard underflow flag.

## Operation
- Storage: NREG x XLEN. x0 always reads 0. Writes and reservations to x0 are ignored. pending[0] is always 0.
- Reset: regs[1..NREG-1]=RST_VAL, every pending=0, err=0. Reset overrides any concurrent issue or wb.
- Write: when wb_valid and wb_rd!=0, regs[wb_rd]<=wb_data and pending[wb_rd] decrements.
  - If pending[wb_rd] is 0 at that edge, the count stays 0, err is set to 1 and the data is still written.
- Issue: the handshake is issue_valid && issue_ready. It increments pending[issue_rd] when issue_rd!=0.
  - issue_ready=0 only when pending[issue_rd]==MAX (2^PCNT_W-1) and no wb to issue_rd occurs in the same cycle.
  - issue_ready=1 for issue_rd=0.
- Same-cycle issue and wb to the same register: the count is unchanged and the write still happens.
- Read, per port n: src_n = regs[rs_n]; busy_n = (pending[rs_n]!=0). For rs_n=0: src_n=0 and busy_n=0.
- err is cleared only by rst.

## Timing
- Reads are combinational, zero latency.
- Without bypass, a write is visible on src the cycle after the wb edge.
- Counter and err updates take effect at posedge. busy and issue_ready reflect the updated counters in the following cycle.
- Outputs after reset: src=RST_VAL (0 for x0), busy=0, issue_ready=1, err=0.
- rst asserted mid-operation discards all outstanding reservations. A wb arriving after reset for a previously reserved register raises err.

## Configuration
- REGFILE_BYPASS_EN defined: write-to-read forwarding is enabled.
  - If wb_valid, wb_rd==rs_n and rs_n!=0: src_n=wb_data in the same cycle, and busy_n=(pending[rs_n]>1).
  - The pending>1 rule means the flag stays set only if another write is still outstanding.
- REGFILE_BYPASS_EN undefined: no forwarding. src_n comes from storage and busy_n=(pending[rs_n]!=0), even during the wb cycle.

## Test plan
- Reset, then read all registers -> every src=0 (RST_VAL=0), busy=0, issue_ready=1, err=0.
- Issue x5; next cycle rs1=5 -> busy1=1. Wb x5=0xDEADBEEF -> with bypass, src1=0xDEADBEEF and busy1=0 in the wb cycle. Without bypass, busy1=1 in the wb cycle, then src1=0xDEADBEEF and busy1=0 the next cycle.
- Issue x7 three times (PCNT_W=2) -> issue_ready=0 on the fourth attempt. Fourth issue coincident with wb x7 -> accepted, count stays 3.
- Issue and wb to x0 with data 0x1234 -> src1(rs1=0)=0, busy1=0, err=0.
- Wb x9 with pending[9]=0 -> regs[9] updated, err=1, err stays 1 until rst.
- Issue x3 twice, assert rst, wb x3 -> after reset busy=0, and the wb sets err=1.

Source files
------------

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: integer register file with two combinational read
// ports, one write-back port and a per-register pending-write counter.
// Decode reserves a destination at issue; write-back retires it. Each read
// port reports a busy flag so decode can stall on RAW hazards.
//
// Optional feature: define REGFILE_BYPASS_EN to forward write-back data to
// the read ports in the same cycle. With it undefined, reads always come
// from storage and the busy flags ignore the in-flight write-back.
module regfile_scoreboard #(
  parameter int               XLEN    = 32,
  parameter int               NREG    = 16,
  parameter int               AW      = $clog2(NREG),
  parameter int               PCNT_W  = 2,
  parameter logic [XLEN-1:0]  RST_VAL = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [AW-1:0]   rs1,
  input  logic [AW-1:0]   rs2,
  output logic [XLEN-1:0] src1,
  output logic [XLEN-1:0] src2,
  output logic            busy1,
  output logic            busy2,
  input  logic            issue_valid,
  input  logic [AW-1:0]   issue_rd,
  output logic            issue_ready,
  input  logic            wb_valid,
  input  logic [AW-1:0]   wb_rd,
  input  logic [XLEN-1:0] wb_data,
  output logic            err
);

  // Saturation value of a pending counter: no more reservations beyond it.
  localparam logic [PCNT_W-1:0] PMAX = '1;
  localparam logic [PCNT_W-1:0] PONE = PCNT_W'(1);

  logic [XLEN-1:0]   regs    [NREG];
  logic [PCNT_W-1:0] pending [NREG];

  logic issue_fire;
  logic wb_fire;

  // A full counter can still take a reservation when a write-back to the
  // same register retires one in this cycle; x0 never blocks.
  assign issue_ready = (issue_rd == '0) ||
                       (pending[issue_rd] != PMAX) ||
                       (wb_valid && (wb_rd == issue_rd));

  assign issue_fire = issue_valid && issue_ready && (issue_rd != '0);
  assign wb_fire    = wb_valid && (wb_rd != '0);

  // Storage, pending counters and the sticky underflow flag; x0 is held at
  // zero with no reservations and is never written.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) begin
        regs[i]    <= RST_VAL;
        pending[i] <= '0;
      end
      regs[0] <= '0;
      err     <= 1'b0;
    end else begin
      if (wb_fire) begin
        regs[wb_rd] <= wb_data;
        if (pending[wb_rd] == '0) begin
          err <= 1'b1;
        end
      end
      for (int i = 1; i < NREG; i++) begin
        if (issue_fire && (issue_rd == AW'(i)) &&
            !(wb_fire && (wb_rd == AW'(i)))) begin
          pending[i] <= pending[i] + PONE;
        end else if (wb_fire && (wb_rd == AW'(i)) &&
                     !(issue_fire && (issue_rd == AW'(i))) &&
                     (pending[i] != '0)) begin
          pending[i] <= pending[i] - PONE;
        end
      end
    end
  end

  // Read port 1: storage value and busy flag, optionally forwarding the
  // write-back that retires the addressed register this cycle.
  always_comb begin
    src1  = regs[rs1];
    busy1 = (pending[rs1] != '0);
`ifdef REGFILE_BYPASS_EN
    if (wb_valid && (wb_rd == rs1) && (rs1 != '0)) begin
      src1  = wb_data;
      busy1 = (pending[rs1] > PONE);
    end
`endif
    if (rs1 == '0) begin
      src1  = '0;
      busy1 = 1'b0;
    end
  end

  // Read port 2: same behaviour as port 1.
  always_comb begin
    src2  = regs[rs2];
    busy2 = (pending[rs2] != '0);
`ifdef REGFILE_BYPASS_EN
    if (wb_valid && (wb_rd == rs2) && (rs2 != '0)) begin
      src2  = wb_data;
      busy2 = (pending[rs2] > PONE);
    end
`endif
    if (rs2 == '0) begin
      src2  = '0;
      busy2 = 1'b0;
    end
  end

endmodule
